// File: rtl/inc_arb_pkg.sv
// Shared definitions for the round-robin increment arbiter: default sizes
// and the rotating-priority search used by the grant logic.
package inc_arb_pkg;

  localparam int INC_ARB_NREQ = 3;
  localparam int INC_ARB_W    = 70;

  // Result of a round-robin search; idx is sized for the largest
  // supported requester count (8).
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Finds the first set bit of valid, starting at ptr and wrapping at nreq.
  // Bits of valid at or above nreq are ignored.
  function automatic rr_pick_t rr_pick(input logic [7:0] valid,
                                       input logic [2:0] ptr,
                                       input int         nreq);
    rr_pick_t r;
    int       j;
    r = '0;
    j = 0;
    for (int k = 0; k < 8; k++) begin
      if (k < nreq && !r.found) begin
        j = int'(ptr) + k;
        if (j >= nreq) j = j - nreq;
        if (valid[3'(j)]) begin
          r.found = 1'b1;
          r.idx   = 3'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/inc_arbiter_rr_arbiter.sv
// Combinational round-robin grant selector: one-hot grant plus its index,
// searching from ptr upward and wrapping. Nothing is granted when en is low.
module rr_arbiter
  import inc_arb_pkg::*;
#(
  parameter int NREQ = INC_ARB_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  rr_pick_t pick;

  // Rotating-priority search, gated by en so a blocked slot grants nobody.
  always_comb begin
    pick    = rr_pick(8'(req), 3'(ptr), NREQ);
    gnt     = '0;
    gnt_idx = '0;
    if (en && pick.found) begin
      gnt_idx = IDW'(pick.idx);
      gnt     = NREQ'(1) << gnt_idx;
    end
  end

endmodule

// File: rtl/inc_arbiter.sv
// Shares one W-bit incrementer among NREQ requesters. A round-robin grant is
// issued whenever the one-entry output register is free (or draining in the
// same cycle); the registered result carries operand+1 and the requester ID.
module inc_arbiter
  import inc_arb_pkg::*;
#(
  parameter int NREQ = INC_ARB_NREQ,
  parameter int W    = INC_ARB_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic [IDW-1:0]  rsp_id,
  output logic [15:0]     grant_cnt
);

  logic [IDW-1:0]  ptr;
  logic            slot_free;
  logic            grant_en;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            accept;
  logic [W-1:0]    sel_data;
  logic [W-1:0]    inc_data;
  logic [IDW-1:0]  ptr_next;

  // The slot counts as free when it is empty or being drained this cycle;
  // no grants are offered while reset is held so outputs read all-zero.
  assign slot_free = !rsp_valid || rsp_ready;
  assign grant_en  = slot_free && !reset;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (grant_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  // Operand mux feeding the single shared incrementer.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_data = req_data[i*W +: W];
    end
  end

  assign inc_data = sel_data + W'(1);
  assign ptr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

  // Priority pointer advances past the requester just served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_next;
    end
  end

  // One-entry output register: load on accept, clear on drain, hold on stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= inc_data;
      rsp_id    <= gnt_idx;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Saturating count of accepted requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt <= '0;
    end else if (accept && grant_cnt != 16'hFFFF) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_inc_arbiter.sv
// Directed self-checking bench for inc_arbiter (3 requesters, 70-bit data).
module tb_inc_arbiter;

  localparam int NREQ = 3;
  localparam int W    = 70;
  localparam int IDW  = 2;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       grant_cnt;

  int n_compared;
  int n_mismatched;

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] D0 = 70'h100;
  localparam logic [W-1:0] D1 = 70'h200;
  localparam logic [W-1:0] D2 = 70'h00_FFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] E0 = 70'h101;
  localparam logic [W-1:0] E1 = 70'h201;
  localparam logic [W-1:0] E2 = 70'h01_0000_0000_0000_0000;

  inc_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .grant_cnt (grant_cnt)
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [79:0] observed,
                             input logic [79:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid,
                               input logic [W-1:0] d0, input logic [W-1:0] d1,
                               input logic [W-1:0] d2, input logic ready);
    req_valid = valid;
    req_data  = {d2, d1, d0};
    rsp_ready = ready;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset = 1'b1;
    applyStimulus(3'b000, '0, '0, '0, 1'b0);
    #1;

    // Reset values
    checkOutput("reset_rsp_valid", 80'(rsp_valid), 80'd0);
    checkOutput("reset_rsp_data",  80'(rsp_data),  80'd0);
    checkOutput("reset_rsp_id",    80'(rsp_id),    80'd0);
    checkOutput("reset_grant_cnt", 80'(grant_cnt), 80'd0);
    checkOutput("reset_req_ready", 80'(req_ready), 80'd0);
    nextCycle();
    reset = 1'b0;
    nextCycle();

    // Single request from requester 1
    applyStimulus(3'b010, '0, 70'h5, '0, 1'b1);
    #1;
    checkOutput("single_req_ready", 80'(req_ready), 80'b010);
    nextCycle();
    checkOutput("single_rsp_valid", 80'(rsp_valid), 80'd1);
    checkOutput("single_rsp_data",  80'(rsp_data),  80'h6);
    checkOutput("single_rsp_id",    80'(rsp_id),    80'd1);
    checkOutput("single_grant_cnt", 80'(grant_cnt), 80'd1);
    // Pointer now at 2: with everyone valid, requester 2 wins
    applyStimulus(3'b111, D0, D1, D2, 1'b1);
    #1;
    checkOutput("ptr_after_single", 80'(req_ready), 80'b100);

    // Wrap: all-ones operand from requester 2
    applyStimulus(3'b100, '0, '0, ALL_ONES, 1'b1);
    #1;
    checkOutput("wrap_req_ready", 80'(req_ready), 80'b100);
    nextCycle();
    checkOutput("wrap_rsp_data",  80'(rsp_data),  80'd0);
    checkOutput("wrap_rsp_id",    80'(rsp_id),    80'd2);
    checkOutput("wrap_rsp_valid", 80'(rsp_valid), 80'd1);
    applyStimulus(3'b111, D0, D1, D2, 1'b0);
    rsp_ready = 1'b1;
    #1;
    checkOutput("ptr_after_wrap", 80'(req_ready), 80'b001);

    // Asynchronous reset mid-cycle with a result pending
    reset = 1'b1;
    #1;
    checkOutput("async_rsp_valid", 80'(rsp_valid), 80'd0);
    checkOutput("async_rsp_id",    80'(rsp_id),    80'd0);
    checkOutput("async_grant_cnt", 80'(grant_cnt), 80'd0);
    checkOutput("async_req_ready", 80'(req_ready), 80'd0);
    applyStimulus(3'b000, '0, '0, '0, 1'b1);
    nextCycle();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nextCycle();
      checkOutput("post_reset_idle", 80'(rsp_valid), 80'd0);
    end

    // Round-robin with everyone valid for 6 cycles
    applyStimulus(3'b111, D0, D1, D2, 1'b1);
    for (int k = 0; k < 6; k++) begin
      nextCycle();
      checkOutput("rr_rsp_valid", 80'(rsp_valid), 80'd1);
      checkOutput("rr_rsp_id",    80'(rsp_id),    80'(k % 3));
      checkOutput("rr_rsp_data",  80'(rsp_data),
                  80'((k % 3 == 0) ? E0 : (k % 3 == 1) ? E1 : E2));
    end
    req_valid = 3'b000;
    checkOutput("rr_grant_cnt", 80'(grant_cnt), 80'd6);

    // Backpressure: result from requester 2 held for 4 cycles
    applyStimulus(3'b111, D0, D1, D2, 1'b0);
    #1;
    checkOutput("bp_req_ready", 80'(req_ready), 80'd0);
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      checkOutput("bp_rsp_valid", 80'(rsp_valid), 80'd1);
      checkOutput("bp_rsp_id",    80'(rsp_id),    80'd2);
      checkOutput("bp_rsp_data",  80'(rsp_data),  80'(E2));
      checkOutput("bp_req_ready", 80'(req_ready), 80'd0);
      checkOutput("bp_grant_cnt", 80'(grant_cnt), 80'd6);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 80'(req_ready), 80'b001);
    nextCycle();
    checkOutput("bp_new_rsp_id",   80'(rsp_id),    80'd0);
    checkOutput("bp_new_rsp_data", 80'(rsp_data),  80'(E0));
    checkOutput("bp_new_grant",    80'(grant_cnt), 80'd7);
    req_valid = 3'b000;
    nextCycle();
    checkOutput("drain_rsp_valid", 80'(rsp_valid), 80'd0);

    // Counter saturation after 65540 more accepts
    applyStimulus(3'b111, D0, D1, D2, 1'b1);
    repeat (65540) @(posedge clk);
    #1;
    checkOutput("sat_grant_cnt", 80'(grant_cnt), 80'hFFFF);
    checkOutput("sat_rsp_valid", 80'(rsp_valid), 80'd1);
    req_valid = 3'b000;
    nextCycle();
    checkOutput("sat_hold", 80'(grant_cnt), 80'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
